// File: rtl/jpeg_pkg.sv
// Shared constants for the JPEG entropy-prep path: field widths, zigzag scan
// order and the zigzag_rle state encoding.
package jpeg_pkg;

  localparam int COEF_W  = 8;
  localparam int N_COEF  = 64;
  localparam int RUN_W   = 6;
  localparam int BLOCK_W = N_COEF * COEF_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EOB  = 2'd2,
    ST_DONE = 2'd3
  } zz_state_e;

  // Raster index (r*8+col) of the k-th coefficient in JPEG zigzag order.
  localparam logic [5:0] ZIGZAG [N_COEF] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zigzag_rle_if.sv
// Symbol stream carrying (run, level) pairs and the end-of-block marker.
// Handshake: a symbol transfers on a rising edge where sym_valid and sym_ready
// are both 1; while sym_valid=1 and sym_ready=0 the source holds run, level
// and eob stable, and sym_valid never drops without a transfer.
interface zigzag_rle_if;
  import jpeg_pkg::*;

  logic              sym_valid;
  logic              sym_ready;
  logic [RUN_W-1:0]  sym_run;
  logic [COEF_W-1:0] sym_level;
  logic              sym_eob;

  modport master (
    output sym_valid, sym_run, sym_level, sym_eob,
    input  sym_ready
  );

  modport slave (
    input  sym_valid, sym_run, sym_level, sym_eob,
    output sym_ready
  );

endinterface

// File: rtl/zigzag_rom.sv
// Combinational zigzag position to raster index lookup.
module zigzag_rom
  import jpeg_pkg::*;
(
  input  logic [5:0] k,
  output logic [5:0] raster
);

  assign raster = ZIGZAG[k];

endmodule

// File: rtl/zigzag_rle.sv
// Captures a quantized 8x8 block, walks it in zigzag order and emits
// (run, level) symbols followed by an EOB symbol, then signals done.
module zigzag_rle
  import jpeg_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [BLOCK_W-1:0]  c,
  zigzag_rle_if.master        sym,
  output logic                busy,
  output logic                done,
  output zz_state_e           state_dbg
);

  zz_state_e          state, state_n;
  logic [5:0]         k, k_n;
  logic [RUN_W-1:0]   run, run_n;
  logic [BLOCK_W-1:0] block;
  logic               block_load;

  logic               sym_valid_q, sym_valid_n;
  logic [RUN_W-1:0]   sym_run_q, sym_run_n;
  logic [COEF_W-1:0]  sym_level_q, sym_level_n;
  logic               sym_eob_q, sym_eob_n;
  logic               done_q, done_n;

  logic [5:0]         raster;
  logic [COEF_W-1:0]  coef;
  logic               coef_nz;
  logic               slot_free;

  zigzag_rom u_rom (
    .k      (k),
    .raster (raster)
  );

  assign coef      = block[int'(raster)*COEF_W +: COEF_W];
  assign coef_nz   = |coef;
  assign slot_free = !sym_valid_q || sym.sym_ready;

  always_comb begin
    state_n     = state;
    k_n         = k;
    run_n       = run;
    block_load  = 1'b0;
    // A pending symbol retires on handshake unless something reloads the slot.
    sym_valid_n = sym_valid_q && !sym.sym_ready;
    sym_run_n   = sym_run_q;
    sym_level_n = sym_level_q;
    sym_eob_n   = sym_eob_q;
    done_n      = done_q;

    case (state)
      ST_IDLE: begin
        if (en) begin
          block_load = 1'b1;
          k_n        = 6'd0;
          run_n      = '0;
          state_n    = ST_SCAN;
        end
      end

      ST_SCAN: begin
        // DC is always emitted; AC zeros only extend the run.
        if (k == 6'd0 || coef_nz) begin
          if (slot_free) begin
            sym_valid_n = 1'b1;
            sym_run_n   = run;
            sym_level_n = coef;
            sym_eob_n   = 1'b0;
            run_n       = '0;
            k_n         = k + 6'd1;
            if (k == 6'd63) state_n = ST_EOB;
          end
        end else begin
          run_n = run + 6'd1;
          k_n   = k + 6'd1;
          if (k == 6'd63) state_n = ST_EOB;
        end
      end

      ST_EOB: begin
        if (sym_valid_q && sym_eob_q && sym.sym_ready) begin
          sym_valid_n = 1'b0;
          sym_eob_n   = 1'b0;
          done_n      = 1'b1;
          state_n     = ST_DONE;
        end else if (slot_free && !sym_eob_q) begin
          sym_valid_n = 1'b1;
          sym_run_n   = '0;
          sym_level_n = '0;
          sym_eob_n   = 1'b1;
        end
      end

      ST_DONE: begin
        // Wait for en to drop so a level-high en cannot re-encode this block.
        if (!en) begin
          done_n  = 1'b0;
          state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      k           <= '0;
      run         <= '0;
      block       <= '0;
      sym_valid_q <= 1'b0;
      sym_run_q   <= '0;
      sym_level_q <= '0;
      sym_eob_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_n;
      k           <= k_n;
      run         <= run_n;
      if (block_load) block <= c;
      sym_valid_q <= sym_valid_n;
      sym_run_q   <= sym_run_n;
      sym_level_q <= sym_level_n;
      sym_eob_q   <= sym_eob_n;
      done_q      <= done_n;
    end
  end

  assign sym.sym_valid = sym_valid_q;
  assign sym.sym_run   = sym_run_q;
  assign sym.sym_level = sym_level_q;
  assign sym.sym_eob   = sym_eob_q;
  assign done          = done_q;
  assign busy          = (state == ST_SCAN) || (state == ST_EOB);
  assign state_dbg     = state;

endmodule

// File: tb/tb_zigzag_rle.sv
// Randomized bench for zigzag_rle: a diagonal-walk zigzag model builds the
// expected symbol stream and a negedge monitor scores every handshake.
module tb_zigzag_rle;
  import jpeg_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [BLOCK_W-1:0] c;
  logic               busy;
  logic               done;
  zz_state_e          state_dbg;

  zigzag_rle_if sym_bus ();

  zigzag_rle dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .c         (c),
    .sym       (sym_bus),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int          zz_ref[64];
  logic [7:0]  blk[64];
  bit          mon_en = 1'b0;
  int          ready_pct = 100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_sym(input bit eob, input int run, input logic [7:0] lvl);
    return {17'd0, eob, 6'(run), lvl};
  endfunction

  // Zigzag order derived by walking anti-diagonals, alternating direction.
  function automatic void build_zz();
    int idx = 0;
    for (int s = 0; s < 15; s++) begin
      int lo;
      int hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_ref[idx] = r * 8 + (s - r); idx++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_ref[idx] = r * 8 + (s - r); idx++; end
      end
    end
  endfunction

  function automatic void push_expected();
    int run = 0;
    for (int k = 0; k < 64; k++) begin
      logic [7:0] v;
      v = blk[zz_ref[k]];
      if (k == 0) exp_q.push_back(pack_sym(1'b0, 0, v));
      else if (v != 8'd0) begin
        exp_q.push_back(pack_sym(1'b0, run, v));
        run = 0;
      end else run++;
    end
    exp_q.push_back(pack_sym(1'b1, 0, 8'd0));
  endfunction

  function automatic void clr_block();
    for (int i = 0; i < 64; i++) blk[i] = 8'd0;
  endfunction

  function automatic void rand_block(input int density);
    for (int i = 0; i < 64; i++)
      blk[i] = ($urandom_range(0, 99) < density) ? 8'($urandom_range(1, 255)) : 8'd0;
  endfunction

  always @(negedge clk) begin
    logic [31:0] got;
    if (mon_en && !rst && sym_bus.sym_valid && sym_bus.sym_ready) begin
      got = pack_sym(sym_bus.sym_eob, int'(sym_bus.sym_run), sym_bus.sym_level);
      if (exp_q.size() == 0) check("sym_extra", got, 32'hFFFF_FFFF);
      else check("sym", got, exp_q.pop_front());
    end
  end

  // Present the block and let the next edge capture it.
  task automatic start_block();
    push_expected();
    for (int i = 0; i < 64; i++) c[i*COEF_W +: COEF_W] = blk[i];
    en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(output int n);
    logic prev_busy;
    n = 0;
    prev_busy = busy;
    while (!done && n < 600) begin
      prev_busy = busy;
      @(posedge clk); n++; #1;
      if (ready_pct < 100) sym_bus.sym_ready = ($urandom_range(0, 99) < ready_pct);
    end
    sym_bus.sym_ready = 1'b1;
    if (!done) check("done_timeout", 32'(done), 32'd1);
    else begin
      check("busy_before_done", 32'(prev_busy), 32'd1);
      check("busy_at_done", 32'(busy), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic finish_block();
    en = 1'b0;
    @(posedge clk); #1;
    check("done_clear", 32'(done), 32'd0);
    check("back_idle", 32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    build_zz();
    rst = 1'b1; en = 1'b0; c = '0; sym_bus.sym_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_valid", 32'(sym_bus.sym_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0; mon_en = 1'b1;
    @(posedge clk); #1;

    // DC-only block, ready tied high: 66 edges capture to done.
    clr_block(); blk[0] = 8'd12;
    start_block();
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(n);
    check("t1_latency", 32'(n), 32'd66);
    finish_block();

    // Negative AC and a run of one.
    clr_block(); blk[1] = 8'hFD; blk[16] = 8'd5;
    start_block(); wait_done(n);
    check("t2_latency", 32'(n), 32'd66);
    finish_block();

    // Only the last coefficient nonzero: run of 62.
    clr_block(); blk[63] = 8'd7;
    start_block(); wait_done(n);
    finish_block();

    // Every coefficient 1: 64 symbols plus EOB, same latency.
    for (int i = 0; i < 64; i++) blk[i] = 8'd1;
    start_block(); wait_done(n);
    check("t4_latency", 32'(n), 32'd66);
    finish_block();

    // Backpressure on (1,5) for 5 cycles.
    clr_block(); blk[1] = 8'hFD; blk[16] = 8'd5;
    start_block();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (sym_bus.sym_valid && sym_bus.sym_level == 8'hFD) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("stall_setup", 32'(found), 32'd1);
    @(posedge clk); #1;
    sym_bus.sym_ready = 1'b0;
    for (int i = 0; i < 10 && !sym_bus.sym_valid; i++) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      check("stall_hold", {sym_bus.sym_valid, 15'(pack_sym(sym_bus.sym_eob, int'(sym_bus.sym_run), sym_bus.sym_level))},
            {1'b1, 15'(pack_sym(1'b0, 1, 8'd5))});
      @(posedge clk); #1;
    end
    sym_bus.sym_ready = 1'b1;
    wait_done(n);
    finish_block();

    // Reset while scanning k=20, then a fresh encode with en held high.
    rand_block(40);
    start_block();
    repeat (20) begin @(posedge clk); #1; end
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1; #1;
    check("mid_rst_valid", 32'(sym_bus.sym_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    push_expected();
    wait_done(n);
    finish_block();

    // Level-high en after done must not re-encode.
    rand_block(30); ready_pct = 60;
    start_block(); wait_done(n);
    repeat (10) begin @(posedge clk); #1; end
    check("hold_done", 32'(done), 32'd1);
    check("hold_state", 32'(state_dbg), 32'(ST_DONE));
    finish_block();
    rand_block(30);
    start_block(); wait_done(n);
    finish_block();

    // Random blocks with random backpressure.
    for (int t = 0; t < 6; t++) begin
      rand_block($urandom_range(5, 90));
      ready_pct = $urandom_range(30, 100);
      start_block(); wait_done(n);
      finish_block();
    end
    ready_pct = 100;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
